// File: rtl/decode_issue.sv
// RV32I decode/issue stage: classifies format and builds the immediate, then buffers entries in a 2-entry skid buffer.
// One-cycle accept-to-output latency; o_inst_ready is a register (!skid valid), so stalls never ripple combinationally upstream.
module decode_issue #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_inst_valid,
  output logic             o_inst_ready,
  input  logic [31:0]      i_inst,
  output logic             o_dec_valid,
  input  logic             i_dec_ready,
  output logic [31:0]      o_dec_inst,
  output logic [5:0]       o_dec_format,
  output logic [31:0]      o_dec_immediate,
  output logic             o_dec_illegal,
  output logic [CNT_W-1:0] o_issue_count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [5:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } entry_t;

  entry_t           dec_d;
  entry_t           main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, issue;

  always_comb begin
    dec_d      = '0;
    dec_d.inst = i_inst;
    case (i_inst[6:0])
      7'b0110011: dec_d.fmt = 6'b000001;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_d.fmt = 6'b000010;
        dec_d.imm = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      7'b0100011: begin
        dec_d.fmt = 6'b000100;
        dec_d.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      7'b1100011: begin
        dec_d.fmt = 6'b001000;
        dec_d.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_d.fmt = 6'b010000;
        dec_d.imm = {i_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_d.fmt = 6'b100000;
        dec_d.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      default: dec_d.ill = 1'b1;
    endcase
  end

  assign accept = i_inst_valid && !skid_vld_q;
  assign issue  = main_vld_q && i_dec_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (issue) cnt_d = cnt_q + CNT_W'(1);
      // skid is only ever valid while main is valid, so it always refills main first
      if (issue && skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept && (!main_vld_q || issue)) begin
        main_d     = dec_d;
        main_vld_d = 1'b1;
      end else if (issue) begin
        main_vld_d = 1'b0;
      end
      if (accept && main_vld_q && !issue) begin
        skid_d     = dec_d;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_inst_ready    = !skid_vld_q;
  assign o_dec_valid     = main_vld_q;
  assign o_dec_inst      = main_q.inst;
  assign o_dec_format    = main_q.fmt;
  assign o_dec_immediate = main_q.imm;
  assign o_dec_illegal   = main_q.ill;
  assign o_issue_count   = cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a default-width instance plus a CNT_W=4 instance share one stimulus stream.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst, flush, inst_valid, dec_ready;
  logic [31:0] inst;

  logic        inst_ready, dec_valid, dec_illegal;
  logic [31:0] dec_inst, dec_imm, cnt;
  logic [5:0]  dec_fmt;

  logic        w_inst_ready, w_dec_valid, w_dec_illegal;
  logic [31:0] w_dec_inst, w_dec_imm;
  logic [5:0]  w_dec_fmt;
  logic [3:0]  w_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_inst_valid(inst_valid), .o_inst_ready(inst_ready), .i_inst(inst),
    .o_dec_valid(dec_valid), .i_dec_ready(dec_ready),
    .o_dec_inst(dec_inst), .o_dec_format(dec_fmt), .o_dec_immediate(dec_imm),
    .o_dec_illegal(dec_illegal), .o_issue_count(cnt)
  );

  decode_issue #(.CNT_W(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_inst_valid(inst_valid), .o_inst_ready(w_inst_ready), .i_inst(inst),
    .o_dec_valid(w_dec_valid), .i_dec_ready(dec_ready),
    .o_dec_inst(w_dec_inst), .o_dec_format(w_dec_fmt), .o_dec_immediate(w_dec_imm),
    .o_dec_illegal(w_dec_illegal), .o_issue_count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addi x0,x0,k: immediate equals k, so word identity is visible in both inst and imm
  function automatic logic [31:0] wk(input int k);
    return {12'(k), 20'h00013};
  endfunction

  logic [31:0] dv_inst [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                               32'hFFDFF06F, 32'h002081B3, 32'h0000007F};
  logic [5:0]  dv_fmt  [7] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000,
                               6'b100000, 6'b000001, 6'b000000};
  logic [31:0] dv_imm  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                               32'hFFFFFFFC, 32'h00000000, 32'h00000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_k, send_k;
    logic accepted;

    rst = 1'b1; flush = 1'b0; inst_valid = 1'b0; dec_ready = 1'b0; inst = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    chk("rst_fmt", 32'(dec_fmt), 32'd0);
    chk("rst_imm", dec_imm, 32'd0);
    chk("rst_inst", dec_inst, 32'd0);
    chk("rst_illegal", 32'(dec_illegal), 32'd0);
    chk("rst_count", cnt, 32'd0);
    chk("rst_w_count", 32'(w_cnt), 32'd0);
    chk("rst_w_ready", 32'(w_inst_ready), 32'd1);

    // decode table, one word at a time
    dec_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      inst_valid = 1'b1; inst = dv_inst[i];
      tick();
      inst_valid = 1'b0;
      chk($sformatf("dec%0d_valid", i), 32'(dec_valid), 32'd1);
      chk($sformatf("dec%0d_inst", i), dec_inst, dv_inst[i]);
      chk($sformatf("dec%0d_fmt", i), 32'(dec_fmt), 32'(dv_fmt[i]));
      chk($sformatf("dec%0d_imm", i), dec_imm, dv_imm[i]);
      chk($sformatf("dec%0d_ill", i), 32'(dec_illegal), (i == 6) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("dec%0d_count", i), cnt, 32'(i + 1));
      chk($sformatf("dec%0d_drained", i), 32'(dec_valid), 32'd0);
    end

    // backpressure: words 1..6, downstream stalled for three edges
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = wk(1);
    tick();
    chk("bp_ready_after_1st", 32'(inst_ready), 32'd1);
    chk("bp_head_1st", dec_inst, wk(1));
    inst = wk(2);
    tick();
    chk("bp_ready_fall", 32'(inst_ready), 32'd0);
    chk("bp_hold_inst_a", dec_inst, wk(1));
    chk("bp_hold_imm_a", dec_imm, 32'd1);
    inst = wk(3);
    tick();
    chk("bp_hold_inst_b", dec_inst, wk(1));
    chk("bp_hold_imm_b", dec_imm, 32'd1);
    chk("bp_hold_ready", 32'(inst_ready), 32'd0);
    chk("bp_hold_count", cnt, 32'd7);
    dec_ready = 1'b1;
    exp_k = 1; send_k = 3;
    for (int c = 0; c < 20 && exp_k <= 6; c++) begin
      if (dec_valid) begin
        chk("bp_order", dec_inst, wk(exp_k));
        exp_k++;
      end
      accepted = inst_valid && inst_ready;
      tick();
      if (accepted) send_k++;
      if (send_k <= 6) begin
        inst_valid = 1'b1; inst = wk(send_k);
      end else begin
        inst_valid = 1'b0;
      end
    end
    inst_valid = 1'b0;
    chk("bp_all_out", 32'(exp_k), 32'd7);
    chk("bp_count", cnt, 32'd13);
    chk("bp_empty", 32'(dec_valid), 32'd0);

    // flush with both entries full, plus a concurrent issue attempt
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = wk(7);
    tick();
    inst = wk(8);
    tick();
    chk("fl_full", 32'(inst_ready), 32'd0);
    flush = 1'b1; inst = wk(9); dec_ready = 1'b1;
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    chk("fl_valid", 32'(dec_valid), 32'd0);
    chk("fl_ready", 32'(inst_ready), 32'd1);
    chk("fl_count", cnt, 32'd13);
    tick();
    chk("fl_stays_empty", 32'(dec_valid), 32'd0);

    // flush discards a same-cycle accept while ready is high
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = wk(10);
    tick();
    flush = 1'b1; inst = wk(11);
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    chk("fl2_valid", 32'(dec_valid), 32'd0);
    dec_ready = 1'b1;
    inst_valid = 1'b1; inst = wk(12);
    tick();
    inst_valid = 1'b0;
    chk("fl_recover_inst", dec_inst, wk(12));
    tick();
    chk("fl_recover_count", cnt, 32'd14);

    // reset mid-operation with count=5 and both entries full
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      inst_valid = 1'b1; inst = wk(i);
      tick();
      inst_valid = 1'b0;
      tick();
    end
    chk("mr_count5", cnt, 32'd5);
    dec_ready = 1'b0;
    inst_valid = 1'b1; inst = wk(6);
    tick();
    inst = wk(7);
    tick();
    chk("mr_full", 32'(inst_ready), 32'd0);
    rst = 1'b1; dec_ready = 1'b1; inst = wk(8);
    tick();
    rst = 1'b0; inst_valid = 1'b0;
    chk("mr_valid", 32'(dec_valid), 32'd0);
    chk("mr_ready", 32'(inst_ready), 32'd1);
    chk("mr_fmt", 32'(dec_fmt), 32'd0);
    chk("mr_imm", dec_imm, 32'd0);
    chk("mr_inst", dec_inst, 32'd0);
    chk("mr_ill", 32'(dec_illegal), 32'd0);
    chk("mr_count", cnt, 32'd0);

    // wrap: 17 back-to-back issues at full throughput
    dec_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      inst_valid = 1'b1; inst = wk(i);
      tick();
      if (i == 9) begin
        chk("wr_ready", 32'(inst_ready), 32'd1);
        chk("wr_head", dec_inst, wk(9));
        chk("wr_mid_count", cnt, 32'd8);
      end
    end
    inst_valid = 1'b0;
    tick();
    chk("wr_empty", 32'(dec_valid), 32'd0);
    chk("wr_count4", 32'(w_cnt), 32'd1);
    chk("wr_count32", cnt, 32'd17);
    chk("wr_w_inst", w_dec_inst, wk(17));
    chk("wr_w_misc", {24'd0, w_dec_fmt, w_dec_valid, w_dec_illegal}, {24'd0, 6'b000010, 1'b0, 1'b0});
    chk("wr_w_imm", w_dec_imm, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter: CNT_W, default 32, width of the issued-instruction counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_flush  input  1  discards all buffered instructions.
REQ-006 i_inst_valid  input  1  upstream instruction word valid.
REQ-007 o_inst_ready  output  1  block can accept an instruction this cycle.
REQ-008 i_inst  input  32  raw RV32I instruction word.
REQ-009 o_dec_valid  output  1  decoded entry valid.
REQ-010 i_dec_ready  input  1  downstream accepts the decoded entry.
REQ-011 o_dec_inst  output  32  instruction word of the head entry.
REQ-012 o_dec_format  output  6  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J; all-zero means illegal.
REQ-013 o_dec_immediate  output  32  sign-extended immediate of the head entry.
REQ-014 o_dec_illegal  output  1  head entry has an unrecognised opcode.
REQ-015 o_issue_count  output  CNT_W  number of completed output handshakes.

Function
REQ-016 Accept: an instruction is accepted when i_inst_valid && o_inst_ready are both high at a clock edge.
REQ-017 Issue: an entry is issued when o_dec_valid && i_dec_ready are both high at a clock edge.
REQ-018 Format classification by i_inst[6:0]:
- 0110011 gives R.
- 0010011, 0000011, 1100111 and 1110011 give I.
- 0100011 gives S.
- 1100011 gives B.
- 0110111 and 0010111 give U.
- 1101111 gives J.
- Any other value gives format 6'b000000 with illegal=1.
REQ-019 Immediate by format:
- I: sign-extended inst[31:20].
- S: sign-extended {inst[31:25], inst[11:7]}.
- B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}.
- J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R or illegal: 32'h0.
REQ-020 Decode is combinational on i_inst. Inst, format, immediate and illegal are captured together into the entry at accept time.
REQ-021 Latency: an instruction accepted at edge N is presented on the o_dec_* outputs with o_dec_valid=1 after edge N, if the buffer was empty.
REQ-022 Buffering is a 2-entry skid buffer: a main entry (drives the outputs) and a skid entry.
REQ-023 o_inst_ready = !skid_valid, driven directly from a register (no combinational path from i_dec_ready).
REQ-024 Accept with the main entry empty, or with the main entry being issued the same cycle, loads the main entry.
REQ-025 Accept while the main entry is valid and not issued loads the skid entry.
REQ-026 Issue with the skid entry valid moves skid to main and clears skid_valid.
REQ-027 Full throughput: one accept and one issue per cycle is sustained indefinitely when i_dec_ready=1.
REQ-028 Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-029 o_dec_* data outputs hold stable while o_dec_valid=1 and i_dec_ready=0.
REQ-030 i_flush=1 clears main_valid and skid_valid at that edge.
REQ-031 During a flush, any same-cycle accept is discarded and a same-cycle issue does not count.
REQ-032 i_flush has no effect on o_issue_count other than suppressing the increment.
REQ-033 o_issue_count increments by 1 per issue and wraps modulo 2^CNT_W.
REQ-034 Illegal entries are issued like any other entry and are counted.

Reset
REQ-035 At an edge with i_rst=1: main_valid=0, skid_valid=0, o_issue_count=0.
REQ-036 After that edge: o_dec_valid=0, o_inst_ready=1, o_dec_format=0, o_dec_immediate=0, o_dec_inst=0, o_dec_illegal=0.
REQ-037 i_rst has priority over i_flush, accept and issue. Reset mid-stream discards all buffered entries.

Verification
REQ-038 Decode values (i_dec_ready=1, one word each):
- 0xFFF00093 gives format 000010, imm 0xFFFFFFFF.
- 0xFE112E23 gives 000100, imm 0xFFFFFFFC.
- 0xFE000CE3 gives 001000, imm 0xFFFFFFF8.
- 0x123452B7 gives 010000, imm 0x12345000.
- 0xFFDFF06F gives 100000, imm 0xFFFFFFFC.
- 0x002081B3 gives 000001, imm 0.
REQ-039 Illegal: 0x0000007F gives format 0, illegal=1, imm 0. o_issue_count increments on its issue.
REQ-040 Backpressure: stream words 1..6 continuously with i_dec_ready=0 for 3 cycles.
- o_inst_ready falls one cycle after the second accept.
- Outputs hold stable while stalled.
- Words emerge as 1..6 in order; o_issue_count=6.
REQ-041 Flush: with both entries full, assert i_flush together with i_inst_valid.
- Next cycle: o_dec_valid=0, o_inst_ready=1.
- The flushed words never appear; the count is unchanged.
REQ-042 Reset mid-operation: with both entries full and count=5, assert i_rst together with a handshake.
- Next cycle: all outputs are at their reset values, count=0.
REQ-043 Wrap: with CNT_W=4, 17 issues leave o_issue_count=1.
